// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the imem request handshake, and
// drives the IF/ID register. It absorbs memory wait states, stalls, flushes and redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        busy_f
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_pend_q, req_pend_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] hb_instr_q, hb_instr_d;
    logic [31:0] hb_pc_q, hb_pc_d;
    logic [31:0] hb_pc4_q, hb_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        accept;
    logic        waiting;
    logic [31:0] pc_plus4;
    logic        fwd_vld;
    logic [31:0] fwd_instr, fwd_pc, fwd_pc4;

    // Gating with rst lets the request drop the instant reset is asserted.
    assign imem_req  = !rst && (req_pend_q || (state_q == ST_RUN && !stall_f) || state_q == ST_KILL);
    assign imem_addr = fpc_q;
    assign pc_f      = fpc_q;
    assign accept    = imem_req && imem_ready;
    assign waiting   = imem_req && !imem_ready;
    assign pc_plus4  = fpc_q + 32'd4;
    assign busy_f    = (state_q != ST_RUN) || waiting;

    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;

    always_comb begin
        state_d    = state_q;
        redir_d    = redir_q;
        fpc_d      = fpc_q;
        hb_instr_d = hb_instr_q;
        hb_pc_d    = hb_pc_q;
        hb_pc4_d   = hb_pc4_q;
        req_pend_d = accept ? 1'b0 : (waiting ? 1'b1 : req_pend_q);
        fwd_vld    = 1'b0;
        fwd_instr  = imem_rdata;
        fwd_pc     = fpc_q;
        fwd_pc4    = pc_plus4;

        case (state_q)
            ST_RUN: begin
                if (pc_src_e) begin
                    // An unfinished request must keep its address, so park the target.
                    if (waiting) begin
                        redir_d = pc_target_e;
                        state_d = ST_KILL;
                    end else begin
                        fpc_d = pc_target_e;
                    end
                end else if (accept) begin
                    fpc_d = pc_plus4;
                    if (stall_d) begin
                        hb_instr_d = imem_rdata;
                        hb_pc_d    = fpc_q;
                        hb_pc4_d   = pc_plus4;
                        state_d    = ST_HOLD;
                    end else begin
                        fwd_vld = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (pc_src_e) begin
                    fpc_d   = pc_target_e;
                    state_d = ST_RUN;
                end else if (!stall_d) begin
                    fwd_vld   = 1'b1;
                    fwd_instr = hb_instr_q;
                    fwd_pc    = hb_pc_q;
                    fwd_pc4   = hb_pc4_q;
                    state_d   = ST_RUN;
                end
            end
            ST_KILL: begin
                if (pc_src_e) begin
                    redir_d = pc_target_e;
                end
                if (accept) begin
                    fpc_d   = pc_src_e ? pc_target_e : redir_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (flush_d) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!stall_d) begin
            if (fwd_vld) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = fwd_instr;
                ifid_pc_d    = fwd_pc;
                ifid_pc4_d   = fwd_pc4;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            req_pend_q   <= 1'b0;
            redir_q      <= 32'd0;
            fpc_q        <= RESET_PC;
            hb_instr_q   <= 32'd0;
            hb_pc_q      <= 32'd0;
            hb_pc4_q     <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pend_q   <= req_pend_d;
            redir_q      <= redir_d;
            fpc_q        <= fpc_d;
            hb_instr_q   <= hb_instr_d;
            hb_pc_q      <= hb_pc_d;
            hb_pc4_q     <= hb_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-flight sequence, and a
// randomized run against an instruction-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, busy_f;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .busy_f(busy_f)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    always_comb imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        rdy, sf, sd, fl, src;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic        e_valid;
        logic [31:0] e_pcd;
    } vec_t;

    function automatic vec_t V(input logic rdy, sf, sd, fl, src, input logic [31:0] tgt,
                               input logic req, input logic [31:0] addr, input logic busy,
                               input logic vld, input logic [31:0] pcd);
        vec_t v;
        v.rdy = rdy; v.sf = sf; v.sd = sd; v.fl = fl; v.src = src; v.tgt = tgt;
        v.e_req = req; v.e_addr = addr; v.e_busy = busy; v.e_valid = vld; v.e_pcd = pcd;
        return v;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: addresses the fetch should produce and instructions waiting for decode.
    ent_t        q[$];
    ent_t        e;
    logic        m_pend, m_kill, m_valid;
    logic [31:0] m_want, m_kaddr, m_instr, m_pcd, cur;
    logic        exp_req, acc, outst;

    vec_t tbl[28];

    initial begin
        tbl[0]  = V(1,0,0,0,0,0,           1,32'h00,1'b0, 1,32'h00);
        tbl[1]  = V(1,0,0,0,0,0,           1,32'h04,1'b0, 1,32'h04);
        tbl[2]  = V(1,0,0,0,0,0,           1,32'h08,1'b0, 1,32'h08);
        tbl[3]  = V(1,0,0,0,0,0,           1,32'h0C,1'b0, 1,32'h0C);
        tbl[4]  = V(0,0,0,0,0,0,           1,32'h10,1'b1, 0,32'h0);
        tbl[5]  = V(0,0,0,0,0,0,           1,32'h10,1'b1, 0,32'h0);
        tbl[6]  = V(0,0,0,0,0,0,           1,32'h10,1'b1, 0,32'h0);
        tbl[7]  = V(1,0,0,0,0,0,           1,32'h10,1'b0, 1,32'h10);
        tbl[8]  = V(1,0,0,0,0,0,           1,32'h14,1'b0, 1,32'h14);
        tbl[9]  = V(1,0,0,0,0,0,           1,32'h18,1'b0, 1,32'h18);
        tbl[10] = V(1,0,0,0,0,0,           1,32'h1C,1'b0, 1,32'h1C);
        tbl[11] = V(0,0,1,0,0,0,           1,32'h20,1'b1, 1,32'h1C);
        tbl[12] = V(0,1,1,0,0,0,           1,32'h20,1'b1, 1,32'h1C);
        tbl[13] = V(1,1,1,0,0,0,           1,32'h20,1'b0, 1,32'h1C);
        tbl[14] = V(1,1,1,0,0,0,           0,32'h24,1'b1, 1,32'h1C);
        tbl[15] = V(1,0,0,0,0,0,           0,32'h24,1'b1, 1,32'h20);
        tbl[16] = V(1,0,0,0,0,0,           1,32'h24,1'b0, 1,32'h24);
        tbl[17] = V(1,0,0,0,1,32'h40,      1,32'h28,1'b0, 0,32'h0);
        tbl[18] = V(0,0,0,0,1,32'h100,     1,32'h40,1'b1, 0,32'h0);
        tbl[19] = V(0,0,0,0,0,0,           1,32'h40,1'b1, 0,32'h0);
        tbl[20] = V(1,0,0,0,0,0,           1,32'h40,1'b1, 0,32'h0);
        tbl[21] = V(1,0,0,0,0,0,           1,32'h100,1'b0, 1,32'h100);
        tbl[22] = V(1,0,0,0,0,0,           1,32'h104,1'b0, 1,32'h104);
        tbl[23] = V(1,0,1,1,0,0,           1,32'h108,1'b0, 0,32'h0);
        tbl[24] = V(1,0,0,0,0,0,           0,32'h10C,1'b1, 1,32'h108);
        tbl[25] = V(1,0,0,0,1,32'hFFFF_FFFC,1,32'h10C,1'b0, 0,32'h0);
        tbl[26] = V(1,0,0,0,0,0,           1,32'hFFFF_FFFC,1'b0, 1,32'hFFFF_FFFC);
        tbl[27] = V(1,0,0,0,0,0,           1,32'h00,1'b0, 1,32'h00);

        rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
        pc_target_e = 0; imem_ready = 0;
        #2;
        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_pcf",    pc_f, RPC);
        chk("rst_valid",  {31'd0, valid_d}, 32'd0);
        chk("rst_instr",  instr_d, NOP);
        chk("rst_pcd",    pc_d, 32'd0);
        chk("rst_pc4",    pc_plus4_d, 32'd0);
        chk("rst_busy",   {31'd0, busy_f}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 28; i++) begin
            imem_ready = tbl[i].rdy; stall_f = tbl[i].sf; stall_d = tbl[i].sd;
            flush_d = tbl[i].fl; pc_src_e = tbl[i].src; pc_target_e = tbl[i].tgt;
            #1;
            chk($sformatf("v%0d_req", i),  {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_pcf", i),  pc_f, tbl[i].e_addr);
            chk($sformatf("v%0d_busy", i), {31'd0, busy_f}, {31'd0, tbl[i].e_busy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, valid_d}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_instr", i), instr_d, tbl[i].e_valid ? mem(tbl[i].e_pcd) : NOP);
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_pcd", i), pc_d, tbl[i].e_pcd);
                chk($sformatf("v%0d_pc4", i), pc_plus4_d, tbl[i].e_pcd + 32'd4);
            end
            @(negedge clk);
        end

        // Reset arriving while the request for 0x4 is waiting.
        imem_ready = 0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
        #1;
        chk("mr_req_wait", {31'd0, imem_req}, 32'd1);
        chk("mr_addr_wait", imem_addr, 32'h4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_req",   {31'd0, imem_req}, 32'd0);
        chk("mr_pcf",   pc_f, RPC);
        chk("mr_valid", {31'd0, valid_d}, 32'd0);
        chk("mr_instr", instr_d, NOP);
        chk("mr_pcd",   pc_d, 32'd0);
        chk("mr_pc4",   pc_plus4_d, 32'd0);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1;
        #1;
        chk("mr_req_after",  {31'd0, imem_req}, 32'd1);
        chk("mr_addr_after", imem_addr, RPC);
        @(posedge clk);
        #1;
        chk("mr_instr_after", instr_d, mem(RPC));
        chk("mr_valid_after", {31'd0, valid_d}, 32'd1);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_pend = 0; m_kill = 0; m_want = RPC; m_kaddr = 0; m_valid = 0; m_instr = NOP; m_pcd = 0;
        for (int n = 0; n < 3000; n++) begin
            imem_ready  = ($urandom_range(0, 9) < 7);
            stall_f     = ($urandom_range(0, 7) == 0);
            stall_d     = ($urandom_range(0, 5) == 0);
            flush_d     = ($urandom_range(0, 19) == 0);
            pc_src_e    = ($urandom_range(0, 11) == 0);
            pc_target_e = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00};
            #1;
            cur     = m_kill ? m_kaddr : m_want;
            exp_req = m_pend || m_kill || (q.size() == 0 && !stall_f);
            chk("r_req",  {31'd0, imem_req}, {31'd0, exp_req});
            chk("r_pcf",  pc_f, cur);
            chk("r_addr", imem_addr, cur);
            chk("r_busy", {31'd0, busy_f},
                {31'd0, (q.size() != 0) || m_kill || (exp_req && !imem_ready)});

            acc   = exp_req && imem_ready;
            outst = exp_req && !imem_ready;
            if (pc_src_e) begin
                q.delete();
                if (outst) begin
                    m_kill  = 1'b1;
                    m_kaddr = cur;
                end else begin
                    m_kill = 1'b0;
                end
                m_want = pc_target_e;
            end else if (acc) begin
                if (m_kill) begin
                    m_kill = 1'b0;
                end else begin
                    e.instr = mem(cur);
                    e.pc    = cur;
                    q.push_back(e);
                    m_want = cur + 32'd4;
                end
            end
            m_pend = outst;
            if (flush_d) begin
                if (!stall_d && q.size() > 0) e = q.pop_front();
                m_valid = 1'b0;
                m_instr = NOP;
            end else if (!stall_d) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_valid = 1'b1;
                    m_instr = e.instr;
                    m_pcd   = e.pc;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end

            @(posedge clk);
            #1;
            chk("r_valid", {31'd0, valid_d}, {31'd0, m_valid});
            chk("r_instr", instr_d, m_instr);
            if (m_valid) begin
                chk("r_pcd", pc_d, m_pcd);
                chk("r_pc4", pc_plus4_d, m_pcd + 32'd4);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the fetch PC and the instruction-memory request handshake, and drives the IF/ID pipeline register whose `instr_d` output feeds the decode stage (main decoder, ALU decoder, immediate extender). It absorbs variable-latency instruction memory, hazard-unit stalls and flushes, and EX-stage branch/jump redirects. Wrong-path or stalled instructions never reach decode as valid.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): value `instr_d` carries when `valid_d`=0.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_f`  in  1  hazard unit: hold the fetch PC and issue no new request.
- `stall_d`  in  1  hazard unit: hold the IF/ID register.
- `flush_d`  in  1  hazard unit: squash the IF/ID register.
- `pc_src_e`  in  1  redirect request from EX (taken branch or jump).
- `pc_target_e`  in  32  redirect target.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  request address, equal to `pc_f`.
- `imem_ready`  in  1  memory accepts the request and returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_req & imem_ready`.
- `pc_f`  out  32  current fetch PC.
- `instr_d`, `pc_d`, `pc_plus4_d`  out  32 each  IF/ID register contents.
- `valid_d`  out  1  IF/ID holds a real instruction.
- `busy_f`  out  1  fetch cannot deliver this cycle. Asserted when `state`≠RUN or when `imem_req & !imem_ready`.

## Operation
- accept = `imem_req & imem_ready`. `req_pend` is a register that is set when `imem_req & !imem_ready` and cleared on accept.
- Handshake rule: once `imem_req` is high, it stays high with a stable `imem_addr` until accept, regardless of `stall_f`, `stall_d` or `pc_src_e`.
- Request equation: `imem_req` = `req_pend` | (state RUN & !`stall_f`) | state KILL. `imem_req` is 0 in HOLD and while `rst` is high.
- FSM states are RUN, HOLD and KILL.
- RUN, accept, no redirect, !`stall_d`: load IF/ID with `instr_d`=rdata, `pc_d`=`pc_f`, `pc_plus4_d`=`pc_f`+4 and `valid_d`=1. Then `pc_f`←`pc_f`+4.
- RUN, accept, no redirect, `stall_d`: capture rdata, `pc_f` and `pc_f`+4 into the hold buffer. `pc_f`←`pc_f`+4. Go to HOLD.
- RUN, no accept, !`stall_d`: IF/ID takes a bubble (`valid_d`=0, `instr_d`=`NOP_INSTR`).
- HOLD: when `stall_d` drops, move the buffer into IF/ID with `valid_d`=1 and go to RUN.
- Redirect (`pc_src_e`) with no request left outstanding at the edge: any same-cycle accept data is discarded, `pc_f`←`pc_target_e`, go to RUN. This applies from RUN and from HOLD; from HOLD the buffer is dropped.
- Redirect while `imem_req & !imem_ready`: the address must stay stable, so store the target in `redir_q` and go to KILL.
- KILL: wait for accept. On accept, discard the data, `pc_f`←`redir_q`, go to RUN. A newer `pc_src_e` arriving in KILL overwrites `redir_q`.
- IF/ID update priority: `rst` > `flush_d` > `stall_d` > load/bubble. `flush_d` forces `valid_d`=0 and `instr_d`=`NOP_INSTR`.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. Target alignment is not checked.
- Reset values: `pc_f`=`RESET_PC`, `instr_d`=`NOP_INSTR`, `pc_d`=0, `pc_plus4_d`=0, `valid_d`=0, state=RUN, `req_pend`=0, `redir_q`=0, hold buffer cleared.
- Reset asserted mid-request: the request is abandoned, `imem_req` drops immediately, and the first request after release is to `RESET_PC`.

## Timing
- IF/ID is registered. With `imem_ready` tied high, the instruction at address A is on `instr_d` one cycle after `imem_addr`=A. Throughput is 1 instruction per cycle.
- Redirect with no outstanding request: `imem_addr`=target on the next cycle, and target on `instr_d` two cycles after `pc_src_e`.
- Redirect penalty through KILL: the remaining memory wait plus 1 cycle.
- `busy_f`, `imem_req` and `imem_addr` are combinational from registered state plus `stall_f` and `imem_ready`. There is no path from `imem_rdata` to any output other than through registers.

## Test plan
- Reset release, `imem_ready`=1, memory returns 0x00500093, 0x00A00113, …: addresses 0, 4, 8 issued on consecutive cycles; `instr_d`=0x00500093 with `pc_d`=0 one cycle after the first request; `valid_d`=1 continuously.
- `imem_ready` low for 3 cycles at address 0x10: `imem_req` and `imem_addr`=0x10 held stable; three bubbles with `valid_d`=0 and `instr_d`=0x00000013; `busy_f`=1.
- `stall_d`=`stall_f`=1 while the request for 0x20 is pending, then ready: HOLD entered, `imem_req`=0, IF/ID unchanged. On stall release, `instr_d`=data@0x20, `pc_d`=0x20, `pc_plus4_d`=0x24.
- `pc_src_e`=1 with `pc_target_e`=0x100 while the request for 0x40 waits 2 cycles: data@0x40 discarded, then `imem_addr`=0x100, and `valid_d`=0 until data@0x100 arrives.
- `flush_d` and `stall_d` asserted together: `valid_d`=0 and `instr_d`=0x00000013.
- `pc_f`=0xFFFF_FFFC accepted: next `imem_addr`=0 and `pc_plus4_d`=0.
- `rst` asserted mid-wait: all outputs at their reset values asynchronously; the first address after release is `RESET_PC`.
